// File: rtl/mac_dot_acc_pipe_if.sv
// Stream bundle for mac_dot_acc_pipe: operand beats in, dot-product results out.
interface mac_dot_acc_pipe_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int ACC_W  = 48
);
    logic                    ivalid;
    logic                    oready;
    logic                    control;
    logic                    last;
    logic [LANES*DATA_W-1:0] datainA;
    logic [LANES*DATA_W-1:0] datainB;
    logic                    ovalid;
    logic                    iready;
    logic signed [ACC_W-1:0] dataout;
    logic                    overflow;

    modport master (
        output ivalid, control, last, datainA, datainB, iready,
        input  oready, ovalid, dataout, overflow
    );

    modport slave (
        input  ivalid, control, last, datainA, datainB, iready,
        output oready, ovalid, dataout, overflow
    );
endinterface

// File: rtl/mac_dot_acc_pipe.sv
// Signed LANES-wide dot-product accumulator, 4-stage pipe with a global stall on result backpressure.
// Define MAC_ACC_SAT_EN to saturate the accumulator on overflow; otherwise it wraps at ACC_W.
module mac_dot_acc_pipe #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int ACC_W  = 48
) (
    input logic               clock,
    input logic               resetn,
    mac_dot_acc_pipe_if.slave bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);

    logic                     adv;
    logic                     vld_p1, ctl_p1, last_p1;
    logic                     vld_p2, ctl_p2, last_p2;
    logic                     vld_p3, ctl_p3, last_p3;
    logic signed [DATA_W-1:0] a_p1 [LANES];
    logic signed [DATA_W-1:0] b_p1 [LANES];
    logic signed [PROD_W-1:0] prod_p2 [LANES];
    logic signed [SUM_W-1:0]  tree [LANES];
    logic signed [SUM_W-1:0]  sum_p3;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W:0]    acc_wide;
    logic                     ovf_acc;
    logic                     ovf_next;
    logic signed [ACC_W-1:0]  dataout_r;
    logic                     ovalid_r;
    logic                     overflow_r;

    // One guard bit above ACC_W: sign disagreement means the true sum left the range.
    function automatic logic wide_ovf(input logic signed [ACC_W:0] full);
        return full[ACC_W] ^ full[ACC_W-1];
    endfunction

`ifdef MAC_ACC_SAT_EN
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] full);
        if (!wide_ovf(full)) return full[ACC_W-1:0];
        return full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    endfunction
`endif

    assign adv          = !ovalid_r || bus.iready;
    assign bus.oready   = adv;
    assign bus.ovalid   = ovalid_r;
    assign bus.dataout  = dataout_r;
    assign bus.overflow = overflow_r;

    // Pairwise adder tree over the registered products, log2(LANES) levels.
    always_comb begin
        for (int i = 0; i < LANES; i++) tree[i] = SUM_W'(prod_p2[i]);
        for (int s = 1; s < LANES; s = s * 2)
            for (int i = 0; i < LANES; i = i + 2 * s)
                tree[i] = tree[i] + tree[i+s];
    end

    always_comb begin
        acc_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(sum_p3);
        acc_next = ACC_W'(sum_p3);
        ovf_next = 1'b0;
        if (!ctl_p3) begin
`ifdef MAC_ACC_SAT_EN
            acc_next = ovf_acc ? acc : sat_acc(acc_wide);
`else
            acc_next = acc_wide[ACC_W-1:0];
`endif
            ovf_next = ovf_acc | wide_ovf(acc_wide);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_p1     <= 1'b0;
            ctl_p1     <= 1'b0;
            last_p1    <= 1'b0;
            vld_p2     <= 1'b0;
            ctl_p2     <= 1'b0;
            last_p2    <= 1'b0;
            vld_p3     <= 1'b0;
            ctl_p3     <= 1'b0;
            last_p3    <= 1'b0;
            acc        <= '0;
            ovf_acc    <= 1'b0;
            dataout_r  <= '0;
            ovalid_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else if (adv) begin
            // p1: accepted beat flags
            vld_p1   <= bus.ivalid;
            ctl_p1   <= bus.control;
            last_p1  <= bus.last;
            // p2: products
            vld_p2   <= vld_p1;
            ctl_p2   <= ctl_p1;
            last_p2  <= last_p1;
            // p3: lane sum
            vld_p3   <= vld_p2;
            ctl_p3   <= ctl_p2;
            last_p3  <= last_p2;
            // p4: accumulator and result
            if (vld_p3) begin
                acc     <= acc_next;
                ovf_acc <= ovf_next;
            end
            ovalid_r <= vld_p3 && last_p3;
            if (vld_p3 && last_p3) begin
                dataout_r  <= acc_next;
                overflow_r <= ovf_next;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (adv) begin
            for (int i = 0; i < LANES; i++) begin
                a_p1[i]    <= bus.datainA[i*DATA_W +: DATA_W];
                b_p1[i]    <= bus.datainB[i*DATA_W +: DATA_W];
                prod_p2[i] <= PROD_W'(a_p1[i]) * PROD_W'(b_p1[i]);
            end
            sum_p3 <= tree[0];
        end
    end
endmodule
